id_ctrl_stage: RTL and testbench
================================

# id_ctrl_stage

Registered decode/control stage for the pipelined RV32I core. It sits between the IF/ID register and the execute stage, and turns a raw 32-bit instruction into a control bundle and a sign-extended immediate. The bundle is held in an ID/EX output register with a valid/ready handshake, flush support, automatic load-use bubble insertion, and stall/bubble performance counters.

## Interface
- XLEN, 32: datapath width for `pc` and `imm`; legal values 32 or 64.
- CNT_W, 32: width of the performance counters.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  the instruction is accepted this cycle.
- instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- flush  in  1  kill the output register and suppress acceptance this cycle.
- out_valid  out  1  output bundle is valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_pc  out  XLEN  registered pc.
- reg_write, mem_write, mem_read, alu_src, branch, jump, illegal  out  1 each  control bits; `alu_src`=1 selects `imm`.
- alu_op  out  5  ALU operation (package enum).
- funct3_o  out  3  registered funct3, used for load/store size and branch condition.
- rd, rs1, rs2  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- stall_cnt, bubble_cnt  out  CNT_W each  performance counters.

## Operation
- Register-advance condition: `adv = !out_valid || out_ready`.
- `hazard` is asserted when all of these hold:
  - `out_valid`
  - `mem_read`
  - `rd != 0`
  - the incoming instruction uses rs1 or rs2, and that index equals `rd`.
- Register-use by format:
  - rs1 is used by R, I, S and B formats.
  - rs2 is used by R, S and B formats.
  - LUI, AUIPC and JAL use neither.
- `in_ready = adv && !hazard && !flush`.
- Per cycle, in priority order:
  1. `flush`: `out_valid` goes to 0 next cycle and nothing is accepted.
  2. `adv && hazard`: a bubble is loaded (`out_valid` goes to 0) and `bubble_cnt` increments.
  3. `adv && in_valid`: the decoded bundle is loaded.
  4. `adv` with no input: `out_valid` goes to 0.
  5. `!adv`: the bundle holds stable.
- `stall_cnt` increments in every cycle with `in_valid && !in_ready && !flush`.
- Supported opcodes: 03, 13, 17, 23, 33, 37, 63, 67, 6F.
- Illegal instruction (unknown opcode, bad funct7, or an M op when M is compiled out):
  - loaded with `illegal`=1;
  - all write, memory, branch and jump controls 0;
  - `alu_op` = ADD.
- ALU op enum:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.
  - M ops are `{2'b10, funct3}`, i.e. 16–23.
- Opcode-to-ALU-op mapping:
  - Branches use SUB.
  - Loads, stores, AUIPC, JAL and JALR use ADD.
  - LUI uses PASSB.
- Immediates are generated per I/S/B/U/J format and sign-extended to XLEN.
- Control outputs:
  - `reg_write`: opcodes 03, 13, 17, 33, 37, 67, 6F, and 0 if `rd`=0.
  - `branch`: opcode 63.
  - `jump`: opcodes 67 and 6F.
- Counters saturate at all-ones.

## Timing
- Latency: one cycle from acceptance to `out_valid`.
- Load-use penalty: exactly one bubble cycle. The dependent instruction is accepted in the cycle after the load leaves.
- With `!adv`, all outputs stay bit-stable.
- Flush coincident with `out_ready`: the handshake completes and the register is still cleared. The bundle shown was consumed.
- Reset (asynchronous):
  - `out_valid`, all control bits, `alu_op`, `rd`, `rs1`, `rs2`, `imm`, `out_pc`, `funct3_o` and both counters go to 0.
  - `in_ready` is 1 after reset.
- Reset mid-stall: the pending bubble is discarded.

## Configuration
- `RV32M_EN` defined:
  - opcode 33 with funct7 `7'b0000001` decodes to `alu_op` = `{2'b10, funct3}`;
  - `reg_write`=1, `alu_src`=0.
- `RV32M_EN` undefined: those encodings are flagged `illegal`.

## Structure
- Package `ctrl_pkg`:
  - `alu_op_e` enum;
  - opcode localparams (`OP_LOAD` … `OP_JAL`);
  - `ctrl_bundle_t` struct holding every registered output field;
  - `imm_fmt_e` enum.
- Sub-module `imm_gen`: combinational, instr -> XLEN immediate, selected by `imm_fmt_e`.
- Top level contains:
  - the decode comb block;
  - the hazard compare;
  - the output register;
  - the counters.

## Test plan
- addi x1,x0,5 (`0x00500093`), `out_ready`=1 -> next cycle `out_valid`=1, `reg_write`=1, `alu_src`=1, `alu_op`=0, `rd`=1, `imm`=5.
- lw x2,0(x1) (`0x0000A103`) then add x3,x2,x1 (`0x001101B3`) back-to-back -> add is accepted 2 cycles after lw, one `out_valid`=0 cycle between them, `bubble_cnt`=1.
- sub x3,x1,x2 (`0x402081B3`) with `out_ready`=0 for 3 cycles -> bundle stays stable with `alu_op`=1, `stall_cnt`=3 when `in_valid` is held.
- mul x3,x1,x2 (`0x022081B3`):
  - with `RV32M_EN` -> `alu_op`=16, `illegal`=0;
  - without it -> `illegal`=1, `reg_write`=0.
- `flush` asserted while `out_valid`=1 with a pending beq (`0x00208463`) -> `out_valid`=0 next cycle, beq not accepted (`in_ready`=0).
- `rst_n` dropped mid-stream -> all outputs 0 asynchronously, counters 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types, opcodes and ALU-op helper for the RV32I decode stage
package ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       illegal;
        alu_op_e    alu_op;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    // alt selects SUB/SRA (funct7 bit 5) for the register-register forms
    function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate extraction per instruction format, sign-extended to XLEN
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     ins,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (fmt)
            IMM_I:   raw = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   raw = {ins[31:12], 12'h000};
            IMM_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/id_ctrl_stage.sv
// rtl/id_ctrl_stage.sv - RV32I decode stage with ID/EX register, load-use bubbles, counters; RV32M_EN adds M ops
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic             reg_write,
    output logic             mem_write,
    output logic             mem_read,
    output logic             alu_src,
    output logic             branch,
    output logic             jump,
    output logic             illegal,
    output logic [4:0]       alu_op,
    output logic [2:0]       funct3_o,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_bundle_t    dec, q;
    imm_fmt_e        fmt;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            use_rs1, use_rs2;
    logic            adv, hazard;
    logic [XLEN-1:0] imm_w, imm_q, pc_q;

    always_comb begin
        opc        = instr[6:0];
        f3         = instr[14:12];
        f7         = instr[31:25];
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.funct3 = f3;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        fmt        = IMM_NONE;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opc)
            OP_LOAD: begin
                dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                fmt = IMM_I; use_rs1 = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                fmt = IMM_I; use_rs1 = 1'b1;
                dec.alu_op = alu_base(f3, (f3 == 3'b101) && (f7 == 7'h20));
                if ((f3 == 3'b001 && f7 != 7'h00) ||
                    (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20))
                    dec.illegal = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; fmt = IMM_U;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1; dec.alu_src = 1'b1;
                fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_REG: begin
                dec.reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'h00)
                    dec.alu_op = alu_base(f3, 1'b0);
                else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alu_op = alu_base(f3, 1'b1);
                else if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
                    dec.alu_op = alu_op_e'({2'b10, f3});
`else
                    dec.illegal = 1'b1;
`endif
                end else
                    dec.illegal = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                dec.alu_op = ALU_PASSB; fmt = IMM_U;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1; dec.alu_op = ALU_SUB;
                fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JALR: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                fmt = IMM_I; use_rs1 = 1'b1;
            end
            OP_JAL: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; fmt = IMM_J;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.reg_write = 1'b0; dec.mem_write = 1'b0; dec.mem_read = 1'b0;
            dec.alu_src   = 1'b0; dec.branch    = 1'b0; dec.jump     = 1'b0;
            dec.alu_op    = ALU_ADD;
        end
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ins (instr[31:7]),
        .fmt (fmt),
        .imm (imm_w)
    );

    // a load still in ID/EX cannot forward to the instruction right behind it
    assign hazard = in_valid && out_valid && q.mem_read && (q.rd != 5'd0) &&
                    ((use_rs1 && dec.rs1 == q.rd) || (use_rs2 && dec.rs2 == q.rd));
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !hazard && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            if (hazard || !in_valid) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                q         <= dec;
                pc_q      <= pc;
                imm_q     <= imm_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (adv && hazard && !flush && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign out_pc    = pc_q;
    assign imm       = imm_q;
    assign reg_write = q.reg_write;
    assign mem_write = q.mem_write;
    assign mem_read  = q.mem_read;
    assign alu_src   = q.alu_src;
    assign branch    = q.branch;
    assign jump      = q.jump;
    assign illegal   = q.illegal;
    assign alu_op    = q.alu_op;
    assign funct3_o  = q.funct3;
    assign rd        = q.rd;
    assign rs1       = q.rs1;
    assign rs2       = q.rs2;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb/tb_id_ctrl_stage.sv - vector table, directed hazard/stall/flush/reset sequences and random run vs reference model
module tb_id_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, out_pc, imm, stall_cnt, bubble_cnt;
    logic        reg_write, mem_write, mem_read, alu_src, branch, jump, illegal;
    logic [4:0]  alu_op, rd, rs1, rs2;
    logic [2:0]  funct3_o;

    always #5 clk = ~clk;

    id_ctrl_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .reg_write(reg_write),
        .mem_write(mem_write), .mem_read(mem_read), .alu_src(alu_src),
        .branch(branch), .jump(jump), .illegal(illegal), .alu_op(alu_op),
        .funct3_o(funct3_o), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic rw, mw, mr, as, br, jp, ill;
        logic [4:0]  aluop;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
    } exp_t;

    typedef struct packed {
        logic [31:0] w;
        logic [6:0]  ctl;
        logic [4:0]  alu;
        logic [31:0] imm;
    } vec_t;

    int          n_cmp = 0, n_err = 0;
    exp_t        m_b;
    logic        m_valid;
    logic [31:0] m_stall, m_bub, cur_pc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       ok;
        logic [4:0] base [8];
        base = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0;
        e.f3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        ok   = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        e.mr = (op == 7'h03);
        e.mw = (op == 7'h23);
        e.br = (op == 7'h63);
        e.jp = op inside {7'h67, 7'h6F};
        e.rw = (op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F}) && (w[11:7] != 5'd0);
        e.as = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h67, 7'h6F};
        case (op)
            7'h03, 7'h13, 7'h67: e.imm = $signed(w) >>> 20;
            7'h23:               e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:               e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h17, 7'h37:        e.imm = {w[31:12], 12'h000};
            7'h6F:               e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:             e.imm = 32'h0;
        endcase
        if (op == 7'h63) e.aluop = 5'd1;
        if (op == 7'h37) e.aluop = 5'd10;
        if (op == 7'h13) begin
            e.aluop = base[f3];
            if (f3 == 3'd5 && f7 == 7'h20) e.aluop = 5'd7;
            if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) ok = 1'b0;
        end
        if (op == 7'h33) begin
            if (f7 == 7'h00)                     e.aluop = base[f3];
            else if (f7 == 7'h20 && f3 == 3'd0)  e.aluop = 5'd1;
            else if (f7 == 7'h20 && f3 == 3'd5)  e.aluop = 5'd7;
            else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                e.aluop = 5'd16 + {2'b00, f3};
`else
                ok = 1'b0;
`endif
            end else ok = 1'b0;
        end
        if (!ok) begin
            e.rw = 0; e.mw = 0; e.mr = 0; e.as = 0; e.br = 0; e.jp = 0; e.aluop = 5'd0;
        end
        e.ill = !ok;
        return e;
    endfunction

    task automatic compare_state();
        check("out_valid", out_valid, m_valid);
        check("stall_cnt", stall_cnt, m_stall);
        check("bubble_cnt", bubble_cnt, m_bub);
        if (m_valid) begin
            check("ctl", {reg_write, mem_write, mem_read, alu_src, branch, jump, illegal},
                  {m_b.rw, m_b.mw, m_b.mr, m_b.as, m_b.br, m_b.jp, m_b.ill});
            check("alu_op", alu_op, m_b.aluop);
            check("fields", {funct3_o, rd, rs1, rs2}, {m_b.f3, m_b.rd, m_b.rs1, m_b.rs2});
            check("imm", imm, m_b.imm);
            check("out_pc", out_pc, m_b.pc);
        end
    endtask

    // called at a negedge; applies inputs across one rising edge and returns at the next negedge
    task automatic cyc(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        exp_t d;
        logic adv, hz, rdy, u1, u2;
        in_valid = iv; instr = w; out_ready = ordy; flush = fl; pc = cur_pc;
        d = ref_dec(w);
        d.pc = cur_pc;
        u1  = w[6:0] inside {7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63};
        u2  = w[6:0] inside {7'h33, 7'h23, 7'h63};
        adv = !m_valid || ordy;
        hz  = iv && m_valid && m_b.mr && (m_b.rd != 5'd0) &&
              ((u1 && w[19:15] == m_b.rd) || (u2 && w[24:20] == m_b.rd));
        rdy = adv && !hz && !fl;
        #1 check("in_ready", in_ready, rdy);
        if (iv && !rdy && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) m_valid = 1'b0;
        else if (adv && hz) begin
            m_valid = 1'b0;
            if (m_bub != 32'hFFFF_FFFF) m_bub++;
        end else if (adv && iv) begin
            m_valid = 1'b1;
            m_b = d;
        end else if (adv) m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_pc += 32'd4;
        compare_state();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ctl", {reg_write, mem_write, mem_read, alu_src, branch, jump, illegal}, 7'h0);
        check("rst_fields", {alu_op, funct3_o, rd, rs1, rs2}, 23'h0);
        check("rst_imm_pc", {imm, out_pc}, 64'h0);
        check("rst_cnt", {stall_cnt, bubble_cnt}, 64'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_b = '0; m_stall = 0; m_bub = 0;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093, LW = 32'h0000_A103, ADD = 32'h0011_01B3;
    localparam logic [31:0] SUB  = 32'h4020_81B3, BEQ = 32'h0020_8463;

    vec_t vt [16];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc = 32'h0; cur_pc = 32'h1000;
        m_valid = 1'b0; m_b = '0; m_stall = 0; m_bub = 0;
        vt[0]  = '{32'h0050_0093, 7'b1001000, 5'd0,  32'h0000_0005};
        vt[1]  = '{32'h0000_A103, 7'b1011000, 5'd0,  32'h0000_0000};
        vt[2]  = '{32'h0011_01B3, 7'b1000000, 5'd0,  32'h0000_0000};
        vt[3]  = '{32'h4020_81B3, 7'b1000000, 5'd1,  32'h0000_0000};
        vt[4]  = '{32'h0020_8463, 7'b0000100, 5'd1,  32'h0000_0008};
        vt[5]  = '{32'hFE20_AE23, 7'b0101000, 5'd0,  32'hFFFF_FFFC};
        vt[6]  = '{32'h1234_52B7, 7'b1001000, 5'd10, 32'h1234_5000};
        vt[7]  = '{32'hFFFF_F317, 7'b1001000, 5'd0,  32'hFFFF_F000};
        vt[8]  = '{32'hFF9F_F0EF, 7'b1001010, 5'd0,  32'hFFFF_FFF8};
        vt[9]  = '{32'h0000_8067, 7'b0001010, 5'd0,  32'h0000_0000};
`ifdef RV32M_EN
        vt[10] = '{32'h0220_81B3, 7'b1000000, 5'd16, 32'h0000_0000};
`else
        vt[10] = '{32'h0220_81B3, 7'b0000001, 5'd0,  32'h0000_0000};
`endif
        vt[11] = '{32'h0000_007F, 7'b0000001, 5'd0,  32'h0000_0000};
        vt[12] = '{32'h4030_D093, 7'b1001000, 5'd7,  32'h0000_0403};
        vt[13] = '{32'h0400_9093, 7'b0000001, 5'd0,  32'h0000_0040};
        vt[14] = '{32'h4020_D1B3, 7'b1000000, 5'd7,  32'h0000_0000};
        vt[15] = '{32'h0020_B1B3, 7'b1000000, 5'd9,  32'h0000_0000};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, vt[i].w, 1'b1, 1'b0);
            check("tbl_valid", out_valid, 1'b1);
            check("tbl_ctl", {reg_write, mem_write, mem_read, alu_src, branch, jump, illegal}, vt[i].ctl);
            check("tbl_alu", alu_op, vt[i].alu);
            check("tbl_imm", imm, vt[i].imm);
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // load-use: one bubble, dependent add accepted two cycles after the load
        do_reset();
        cyc(1'b1, LW, 1'b1, 1'b0);
        check("lu_load_valid", {out_valid, mem_read}, 2'b11);
        in_valid = 1'b1; instr = ADD; out_ready = 1'b1;
        #1 check("lu_blocked", in_ready, 1'b0);
        cyc(1'b1, ADD, 1'b1, 1'b0);
        check("lu_bubble_valid", out_valid, 1'b0);
        check("lu_bubble_cnt", bubble_cnt, 32'd1);
        check("lu_retry_ready", in_ready, 1'b1);
        cyc(1'b1, ADD, 1'b1, 1'b0);
        check("lu_add_valid", {out_valid, rd}, {1'b1, 5'd3});
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // back-pressure: bundle bit-stable for three cycles, then reset mid-stall
        do_reset();
        cyc(1'b1, SUB, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, ADDI, 1'b0, 1'b0);
            check("st_hold", {out_valid, alu_op, rd}, {1'b1, 5'd1, 5'd3});
        end
        check("st_stall_cnt", stall_cnt, 32'd3);
        do_reset();

        // flush with a pending branch: register cleared, branch not taken in
        cyc(1'b1, ADDI, 1'b1, 1'b0);
        in_valid = 1'b1; instr = BEQ; flush = 1'b1;
        #1 check("fl_ready", in_ready, 1'b0);
        cyc(1'b1, BEQ, 1'b1, 1'b1);
        check("fl_valid", out_valid, 1'b0);
        check("fl_stall", stall_cnt, 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("fl_not_taken", out_valid, 1'b0);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [6:0]  ops [9];
            logic [6:0]  op, f7;
            logic [31:0] w;
            ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
            op  = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            w = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                 5'($urandom_range(0, 3)), op};
            if ($urandom_range(0, 9) == 0) w = $urandom;
            cur_pc = $urandom;
            cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
